int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that sits directly downstream of the timer and the other memory-mapped peripherals, between their `irq` outputs and CP0. Latches up to six interrupt sources in level or edge mode, applies a software mask, and presents one prioritised request to CP0 via a req/ack handshake with end-of-interrupt (EOI) release. Software programs it through the bridge with the same `addr`/`we`/`din`/`dout` register port the peripherals use.

## Interface
- `NSRC`, 6, number of interrupt sources; fixed at 6 in this design.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `addr`  in  3  register select (word index from bridge).
- `we`  in  1  register write enable.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr`.
- `irq_in`  in  6  source lines; bit 0 = timer (highest priority), bit 5 lowest.
- `int_ack`  in  1  one-cycle pulse from CP0 on exception entry.
- `hwint`  out  6  registered `pend & mask`, to CP0 Cause.IP view.
- `int_req`  out  1  request to CP0.
- `int_id`  out  3  index of the requested/in-service source.

## Operation
- Registers (reads of other addresses return 0; reserved bits read 0, ignore writes):
  - addr 0 MASK[5:0]: 1 = enabled.
  - addr 1 MODE[5:0]: 1 = rising-edge, 0 = level.
  - addr 2 PEND[5:0]: read pending; write-1-to-clear, edge-mode bits only.
  - addr 3 ISR: read {28'b0, busy, int_id}; any write = EOI.
  - addr 4 RAW[5:0]: read-only current `irq_in`.
- Pending logic per bit i:
  - Level mode: PEND[i] <= irq_in[i] every cycle; W1C has no effect.
  - Edge mode: PEND[i] set when irq_in[i] & ~prev[i]; cleared by W1C or by `int_ack` when i == int_id. Set beats clear in the same cycle.
  - `prev` registers `irq_in` every cycle; it resets to 0, so a line already high when reset releases counts as an edge.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `pend & mask` is nonzero, latch `int_id` = lowest set index and go to REQ.
  - REQ: `int_req` = 1.
    - `int_ack` -> SERVICE, busy = 1.
    - Otherwise, if `pend[int_id] & mask[int_id]` is 0 (cancelled) -> IDLE and drop `int_req`.
    - `int_id` stays fixed while in REQ, even if a higher-priority source arrives.
  - SERVICE: `int_req` = 0 and `int_id` is held. An EOI write -> IDLE, busy = 0. No nesting.
  - `int_ack` outside REQ is ignored.
- MODE change on a bit: PEND[i] clears on that write cycle. A level bit then resumes tracking on the next cycle.

## Timing
- Reset (`rst` = 0 at posedge): MASK, MODE, PEND, prev, `hwint`, `int_id`, busy all 0; state IDLE; `int_req` = 0. Reset overrides any same-cycle write.
- `irq_in` rising before edge k:
  - PEND set after edge k.
  - `hwint` updated and FSM enters REQ after edge k+1, so `int_req` = 1 two cycles after the input change.
- `int_ack` at edge a: SERVICE after edge a. The edge-mode pending bit is cleared at edge a.
- EOI at edge e: IDLE after edge e. If anything is still pending and masked, REQ after edge e+1.
- Register writes take effect after the write edge. `dout` reflects the new value in the following cycle.
- Cancellation: `int_req` falls the cycle after the mask clear or W1C edge.

## Test plan
- Reset with `irq_in` = 0 -> MASK = MODE = PEND = 0, `int_req` = 0, `int_id` = 0, `dout`@addr0..4 = 0.
- Timer edge (MASK = 6'h01, MODE = 6'h01), pulse irq_in[0] for 1 cycle -> PEND = 1 then `int_req` = 1 two cycles later, `int_id` = 0. `int_ack` -> PEND[0] = 0, `int_req` = 0, ISR reads 8. EOI -> ISR reads 0, `int_req` stays 0.
- Priority (MASK = 6'h3F, level): raise bits 5 and 2 together -> `int_id` = 2. Ack, then EOI while bit 5 is still high -> new REQ with `int_id` = 5.
- Level vs W1C: level source held high, write PEND = 6'h3F -> PEND unchanged. Drop the line -> PEND bit 0 next cycle. Before ack, `int_req` falls (cancel).
- Set beats clear: in edge mode, a rising edge on bit 3 coincides with a W1C of bit 3 -> PEND[3] = 1 afterwards.
- Reset mid-service: in SERVICE with `int_id` = 4, assert `rst` for 1 cycle concurrently with a MASK write -> all registers 0, IDLE, MASK = 0.

Source files
------------

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl - six-source interrupt controller between the peripheral irq lines
// and CP0.
//
// Each source is latched in level or rising-edge mode, gated by a software
// mask, and the lowest-indexed active source is presented to CP0 as a single
// request. CP0 accepts it with a one-cycle int_ack; software releases it with
// an end-of-interrupt write to the ISR register. There is no nesting: a new
// request is only raised after EOI.
//
// Ports
//   clk      in   system clock, all state on posedge
//   rst      in   synchronous active-low reset
//   addr     in   [2:0]  register word index
//   we       in   register write enable
//   din      in   [31:0] write data
//   dout     out  [31:0] read data, combinational from addr
//   irq_in   in   [5:0]  source lines, bit 0 (timer) has highest priority
//   int_ack  in   one-cycle accept pulse from CP0
//   hwint    out  [5:0]  registered pend & mask (Cause.IP view)
//   int_req  out  request to CP0
//   int_id   out  [2:0]  index of the requested / in-service source
//
// Register map (word index)
//   0 MASK[5:0]  1 = enabled
//   1 MODE[5:0]  1 = rising edge, 0 = level
//   2 PEND[5:0]  read pending, write-1-to-clear (edge bits only)
//   3 ISR        read {busy, int_id}, any write = EOI
//   4 RAW[5:0]   current irq_in, read-only
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      addr,
  input  logic            we,
  input  logic [31:0]     din,
  output logic [31:0]     dout,
  input  logic [NSRC-1:0] irq_in,
  input  logic            int_ack,
  output logic [NSRC-1:0] hwint,
  output logic            int_req,
  output logic [2:0]      int_id
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] mode_reg;
  logic [NSRC-1:0] pend_reg;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] prev_reg;
  logic [NSRC-1:0] hwint_reg;
  logic [2:0]      int_id_reg;
  logic [2:0]      int_id_next;
  logic [1:0]      state_reg;
  logic [1:0]      state_next;

  logic            wr_mask;
  logic            wr_mode;
  logic            wr_pend;
  logic            wr_isr;
  logic            ack_take;
  logic            busy;
  logic [NSRC-1:0] active;
  logic [2:0]      first_id;

  // Upper write-data bits are reserved and deliberately ignored.
  logic            unused_din;
  assign unused_din = ^din[31:NSRC];

  assign wr_mask  = we && (addr == 3'd0);
  assign wr_mode  = we && (addr == 3'd1);
  assign wr_pend  = we && (addr == 3'd2);
  assign wr_isr   = we && (addr == 3'd3);

  // An ack is only meaningful while a request is outstanding.
  assign ack_take = int_ack && (state_reg == REQ);
  assign busy     = (state_reg == SERVICE);
  assign active   = pend_reg & mask_reg;

  // Per-source pending update. A MODE flip on a bit wins over everything so
  // the bit starts clean in its new mode; in edge mode a new edge wins over
  // any clear arriving in the same cycle.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
      logic edge_set;
      logic edge_clr;
      assign edge_set = irq_in[gi] & ~prev_reg[gi];
      assign edge_clr = (wr_pend && din[gi]) ||
                        (ack_take && (int_id_reg == 3'(gi)));
      assign pend_next[gi] =
        (wr_mode && (din[gi] != mode_reg[gi])) ? 1'b0 :
        !mode_reg[gi]                          ? irq_in[gi] :
        (edge_set | (pend_reg[gi] & ~edge_clr));
    end
  endgenerate

  // Lowest set index of the active vector: scan downward so the smallest
  // index is the last one written.
  always_comb begin
    first_id = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) first_id = 3'(i);
    end
  end

  // Request FSM. int_id is captured on IDLE->REQ and frozen until the next
  // request, so a higher-priority arrival cannot retarget a pending request.
  always_comb begin
    state_next  = state_reg;
    int_id_next = int_id_reg;
    case (state_reg)
      IDLE: begin
        if (|active) begin
          state_next  = REQ;
          int_id_next = first_id;
        end
      end
      REQ: begin
        if (int_ack)                  state_next = SERVICE;
        else if (!active[int_id_reg]) state_next = IDLE;
      end
      SERVICE: begin
        if (wr_isr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_reg   <= '0;
      mode_reg   <= '0;
      pend_reg   <= '0;
      prev_reg   <= '0;
      hwint_reg  <= '0;
      int_id_reg <= 3'd0;
      state_reg  <= IDLE;
    end else begin
      if (wr_mask) mask_reg <= din[NSRC-1:0];
      if (wr_mode) mode_reg <= din[NSRC-1:0];
      pend_reg   <= pend_next;
      prev_reg   <= irq_in;
      hwint_reg  <= active;
      int_id_reg <= int_id_next;
      state_reg  <= state_next;
    end
  end

  assign hwint   = hwint_reg;
  assign int_req = (state_reg == REQ);
  assign int_id  = int_id_reg;

  always_comb begin
    dout = '0;
    case (addr)
      3'd0:    dout[NSRC-1:0] = mask_reg;
      3'd1:    dout[NSRC-1:0] = mode_reg;
      3'd2:    dout[NSRC-1:0] = pend_reg;
      3'd3:    dout[3:0]      = {busy, int_id_reg};
      3'd4:    dout[NSRC-1:0] = irq_in;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl - scoreboard bench for int_ctrl.
//
// The stimulus process drives one cycle at a time just after each rising
// edge, pushes the outputs the reference model expects for that cycle, then
// advances the model across the coming edge. A monitor on the falling edge
// pops one expectation per cycle and compares it with the DUT outputs.
// Directed scenarios come first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  irq_in;
  logic        int_ack;
  logic [5:0]  hwint;
  logic        int_req;
  logic [2:0]  int_id;

  int_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .hwint   (hwint),
    .int_req (int_req),
    .int_id  (int_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  hwint;
    logic        req;
    logic [2:0]  id;
    logic [31:0] dout;
    logic [2:0]  addr;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference model: the controller as software sees it.
  bit [5:0] m_mask, m_mode, m_pend, m_prev, m_hw;
  bit       m_req, m_busy;
  bit [2:0] m_id;

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [5:0] raw);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0:    r = {26'd0, m_mask};
      3'd1:    r = {26'd0, m_mode};
      3'd2:    r = {26'd0, m_pend};
      3'd3:    r = {28'd0, m_busy, m_id};
      3'd4:    r = {26'd0, raw};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic r, input logic [2:0] a, input logic w,
                            input logic [31:0] d, input logic [5:0] irq, input logic ack);
    bit [5:0] act;
    bit [5:0] np;
    act = m_pend & m_mask;
    if (!r) begin
      m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_hw = 0;
      m_req = 0; m_busy = 0; m_id = 0;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      if (w && a == 3'd1 && d[i] != m_mode[i])
        np[i] = 1'b0;
      else if (!m_mode[i])
        np[i] = irq[i];
      else
        np[i] = (irq[i] && !m_prev[i]) ||
                (m_pend[i] && !(w && a == 3'd2 && d[i]) && !(ack && m_req && m_id == 3'(i)));
    end
    if (m_busy) begin
      if (w && a == 3'd3) m_busy = 0;
    end else if (m_req) begin
      if (ack) begin
        m_req  = 0;
        m_busy = 1;
      end else if (!act[m_id]) begin
        m_req = 0;
      end
    end else if (act != 6'd0) begin
      int k;
      k = 0;
      while (!act[k]) k++;
      m_req = 1;
      m_id  = 3'(k);
    end
    m_hw   = act;
    m_prev = irq;
    m_pend = np;
    if (w && a == 3'd0) m_mask = d[5:0];
    if (w && a == 3'd1) m_mode = d[5:0];
  endtask

  // One bus cycle: drive, queue the expected outputs, advance the model.
  task automatic tick(input logic r, input logic [2:0] a, input logic w,
                      input logic [31:0] d, input logic [5:0] irq, input logic ack);
    exp_t e;
    rst = r; addr = a; we = w; din = d; irq_in = irq; int_ack = ack;
    e.hwint = m_hw;
    e.req   = m_req;
    e.id    = m_id;
    e.dout  = model_read(a, irq);
    e.addr  = a;
    sbq.push_back(e);
    model_step(r, a, w, d, irq, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [5:0] irq);
    tick(1'b1, a, 1'b1, d, irq, 1'b0);
  endtask

  task automatic idle(input int n, input logic [2:0] a, input logic [5:0] irq);
    for (int k = 0; k < n; k++) tick(1'b1, a, 1'b0, 32'd0, irq, 1'b0);
  endtask

  // Ack as soon as the model says a request is up (bounded wait).
  task automatic ack_when_req(input logic [5:0] irq);
    for (int k = 0; k < 8 && !m_req; k++) tick(1'b1, 3'd3, 1'b0, 32'd0, irq, 1'b0);
    tick(1'b1, 3'd3, 1'b0, 32'd0, irq, m_req);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("hwint",   {26'd0, hwint},  {26'd0, e.hwint});
      cmp("int_req", {31'd0, int_req}, {31'd0, e.req});
      cmp("int_id",  {29'd0, int_id}, {29'd0, e.id});
      cmp("dout",    dout, e.dout);
      $display("cyc %0d addr=%0d dout=%h req=%b id=%0d hwint=%h",
               cyc_n, e.addr, dout, int_req, int_id, hwint);
      cyc_n++;
    end
  end

  initial begin
    logic [5:0] cur_irq;
    logic       r;
    logic       w;
    logic       ack;
    logic [2:0] a;

    // Unchecked first edge: DUT state is unknown until reset is sampled.
    rst = 1'b0; addr = 3'd0; we = 1'b0; din = 32'd0; irq_in = 6'd0; int_ack = 1'b0;
    model_step(1'b0, 3'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    @(posedge clk);
    #1;

    // Reset state and register reads.
    tick(1'b0, 3'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    for (int k = 0; k < 5; k++) idle(1, 3'(k), 6'd0);

    // Timer edge: one-cycle pulse, request, ack, EOI.
    wr(3'd0, 32'h01, 6'd0);
    wr(3'd1, 32'h01, 6'd0);
    tick(1'b1, 3'd2, 1'b0, 32'd0, 6'h01, 1'b0);
    idle(2, 3'd2, 6'd0);
    ack_when_req(6'd0);
    idle(1, 3'd2, 6'd0);
    idle(1, 3'd3, 6'd0);
    wr(3'd3, 32'd0, 6'd0);
    idle(3, 3'd3, 6'd0);

    // Priority in level mode: bits 5 and 2 together, then bit 5 alone.
    wr(3'd0, 32'h3F, 6'd0);
    wr(3'd1, 32'h00, 6'd0);
    idle(3, 3'd3, 6'h24);
    ack_when_req(6'h24);
    idle(2, 3'd3, 6'h20);
    wr(3'd3, 32'd0, 6'h20);
    idle(3, 3'd3, 6'h20);
    ack_when_req(6'h20);
    wr(3'd3, 32'd0, 6'h00);
    idle(2, 3'd3, 6'h00);

    // Level source ignores W1C; dropping the line cancels the request.
    wr(3'd0, 32'h01, 6'h01);
    idle(2, 3'd2, 6'h01);
    wr(3'd2, 32'h3F, 6'h01);
    idle(2, 3'd2, 6'h01);
    idle(3, 3'd2, 6'h00);

    // Edge on bit 3 coincides with W1C of bit 3: set wins.
    wr(3'd0, 32'h00, 6'h00);
    wr(3'd1, 32'h08, 6'h00);
    idle(1, 3'd2, 6'h00);
    tick(1'b1, 3'd2, 1'b1, 32'h08, 6'h08, 1'b0);
    idle(2, 3'd2, 6'h08);
    wr(3'd2, 32'h08, 6'h08);
    idle(2, 3'd2, 6'h00);

    // Reset while servicing source 4, with a concurrent MASK write.
    wr(3'd1, 32'h00, 6'h00);
    wr(3'd0, 32'h10, 6'h10);
    ack_when_req(6'h10);
    idle(1, 3'd3, 6'h10);
    tick(1'b0, 3'd0, 1'b1, 32'h3F, 6'h10, 1'b0);
    for (int k = 0; k < 4; k++) idle(1, 3'(k), 6'h10);
    idle(2, 3'd3, 6'h00);

    // Randomized traffic.
    cur_irq = 6'd0;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 7) == 0) cur_irq[b] = ~cur_irq[b];
      r   = ($urandom_range(0, 149) != 0);
      a   = 3'($urandom_range(0, 7));
      w   = ($urandom_range(0, 3) == 0);
      if (m_busy && $urandom_range(0, 5) == 0) begin
        a = 3'd3;
        w = 1'b1;
      end
      ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      tick(r, a, w, $urandom, cur_irq, ack);
    end
    idle(3, 3'd3, 6'd0);

    // Drain the scoreboard (bounded).
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
